apb_req_master: RTL and testbench

APB_REQ_MASTER -- requirements
Module: apb_req_master

---
 rtl/apb_mem_pkg.sv | 23 ++
 rtl/apb_cmd_fifo.sv | 65 ++++++
 rtl/apb_req_master.sv | 155 +++++++++++++++
 tb/tb_apb_req_master.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types for the APB-style request master: default widths,
// FSM state encoding and the queued command layout.
package apb_mem_pkg;

   localparam int unsigned WIDTH_DEF      = 32;
   localparam int unsigned ADDR_WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   // Queued command at the default widths; the master packs the same
   // fields in the same order (wr_rd, addr, wdata) at its own widths.
   typedef struct packed {
      logic                      wr_rd;
      logic [ADDR_WIDTH_DEF-1:0] addr;
      logic [WIDTH_DEF-1:0]      wdata;
   } cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO with registered occupancy count.
// Push is ignored when full, pop is ignored when empty; a simultaneous
// push and pop leaves the count unchanged.
module apb_cmd_fifo #(
   parameter int unsigned DATA_W = 37,
   parameter int unsigned DEPTH  = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              push_s;
   logic              pop_s;

   assign push_s  = push_i & (count_r != FULL_CNT);
   assign pop_s   = pop_i & (count_r != {CNT_W{1'b0}});
   assign full_o  = (count_r == FULL_CNT);
   assign empty_o = (count_r == {CNT_W{1'b0}});
   assign count_o = count_r;
   assign data_o  = mem_r[rd_ptr_r];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         if (push_s && !pop_s) begin
            count_r <= count_r + CNT_W'(1);
         end else if (pop_s && !push_s) begin
            count_r <= count_r - CNT_W'(1);
         end
      end
   end

   // Storage array; contents need no reset because count gates every read.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= data_i;
      end
   end

endmodule

// File: rtl/apb_req_master.sv
// Host-command to memory-slave bridge: queues host commands, runs one
// SETUP/ACCESS transfer at a time with an ACCESS timeout, and returns a
// response (read data or error) through a valid/ready handshake.
module apb_req_master
   import apb_mem_pkg::*;
#(
   parameter int unsigned WIDTH      = WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_wr_rd_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [WIDTH-1:0]      cmd_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [WIDTH-1:0]      rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  valid_o,
   output logic                  wr_rd_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [WIDTH-1:0]      wdata_o,
   input  logic                  ready_i,
   input  logic [WIDTH-1:0]      rdata_i
);

   localparam int unsigned CMD_W = 1 + ADDR_WIDTH + WIDTH;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [CNT_W:0]   FULL_NXT = (CNT_W + 1)'(FIFO_DEPTH);

   state_e            state_r;
   logic [TMO_W-1:0]  tmo_cnt_r;
   logic              cmd_ready_r;
   logic              valid_r;
   logic              wr_rd_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [WIDTH-1:0]  wdata_r;
   logic              rsp_valid_r;
   logic [WIDTH-1:0]  rsp_rdata_r;
   logic              rsp_err_r;

   logic [CMD_W-1:0]  fifo_head_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic [CNT_W-1:0]  fifo_count_s;
   logic              push_s;
   logic              pop_s;
   logic [CNT_W:0]    cnt_next_s;

   // Full check is redundant with cmd_ready_r but keeps the FIFO safe
   // against any disagreement between the two views of occupancy.
   assign push_s     = cmd_valid_i & cmd_ready_r & ~fifo_full_s;
   assign pop_s      = (state_r == ST_IDLE) & ~fifo_empty_s;
   assign cnt_next_s = {1'b0, fifo_count_s}
                     + {{CNT_W{1'b0}}, push_s}
                     - {{CNT_W{1'b0}}, pop_s};

   apb_cmd_fifo #(
      .DATA_W (CMD_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push_s),
      .data_i  ({cmd_wr_rd_i, cmd_addr_i, cmd_wdata_i}),
      .pop_i   (pop_s),
      .data_o  (fifo_head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (fifo_count_s)
   );

   // Registered "queue not full": tracks the FIFO count one edge ahead so
   // the output never depends on the same-cycle pop and is low in reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cmd_ready_r <= 1'b0;
      end else begin
         cmd_ready_r <= (cnt_next_s != FULL_NXT);
      end
   end

   // Transfer FSM with registered slave-side and response-side outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= ST_IDLE;
         tmo_cnt_r   <= {TMO_W{1'b0}};
         valid_r     <= 1'b0;
         wr_rd_r     <= 1'b0;
         addr_r      <= {ADDR_WIDTH{1'b0}};
         wdata_r     <= {WIDTH{1'b0}};
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= {WIDTH{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  {wr_rd_r, addr_r, wdata_r} <= fifo_head_s;
                  state_r <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               valid_r   <= 1'b1;
               tmo_cnt_r <= {TMO_W{1'b0}};
               state_r   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (ready_i) begin
                  valid_r     <= 1'b0;
                  rsp_rdata_r <= wr_rd_r ? {WIDTH{1'b0}} : rdata_i;
                  rsp_err_r   <= 1'b0;
                  rsp_valid_r <= 1'b1;
                  state_r     <= ST_RESP;
               end else if (tmo_cnt_r == TMO_LAST) begin
                  valid_r     <= 1'b0;
                  rsp_rdata_r <= {WIDTH{1'b0}};
                  rsp_err_r   <= 1'b1;
                  rsp_valid_r <= 1'b1;
                  state_r     <= ST_RESP;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_r <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               valid_r     <= 1'b0;
               rsp_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready_o = cmd_ready_r;
   assign valid_o     = valid_r;
   assign wr_rd_o     = wr_rd_r;
   assign addr_o      = addr_r;
   assign wdata_o     = wdata_r;
   assign rsp_valid_o = rsp_valid_r;
   assign rsp_rdata_o = rsp_rdata_r;
   assign rsp_err_o   = rsp_err_r;

endmodule

// File: tb/tb_apb_req_master.sv
// Directed testbench for apb_req_master with a registered-ready memory
// slave model and a response capture log.
module tb_apb_req_master;

   localparam int W  = 32;
   localparam int AW = 4;

   logic          clk_i       = 1'b0;
   logic          rst_ni      = 1'b0;
   logic          cmd_valid_i = 1'b0;
   logic          cmd_wr_rd_i = 1'b0;
   logic [AW-1:0] cmd_addr_i  = 4'h0;
   logic [W-1:0]  cmd_wdata_i = 32'h0;
   logic          rsp_ready_i = 1'b0;
   logic          ready_i;
   logic [W-1:0]  rdata_i;
   logic          cmd_ready_o;
   logic          rsp_valid_o;
   logic [W-1:0]  rsp_rdata_o;
   logic          rsp_err_o;
   logic          valid_o;
   logic          wr_rd_o;
   logic [AW-1:0] addr_o;
   logic [W-1:0]  wdata_o;

   int n_vec = 0;
   int n_bad = 0;
   logic slave_en = 1'b1;
   logic [W-1:0] mem [16] = '{default: 32'h0};
   logic [W-1:0] cap_data [$];
   logic         cap_err  [$];

   apb_req_master #(
      .WIDTH(W), .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .TIMEOUT(16)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_wr_rd_i(cmd_wr_rd_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .valid_o(valid_o), .wr_rd_o(wr_rd_o), .addr_o(addr_o), .wdata_o(wdata_o),
      .ready_i(ready_i), .rdata_i(rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // Memory slave: answers one cycle after seeing valid_o, single-cycle ready.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ready_i <= 1'b0;
         rdata_i <= 32'h0;
      end else if (slave_en && valid_o && !ready_i) begin
         ready_i <= 1'b1;
         if (wr_rd_o) mem[addr_o] <= wdata_o;
         else         rdata_i     <= mem[addr_o];
      end else begin
         ready_i <= 1'b0;
      end
   end

   // Response log: every completed response handshake.
   always @(posedge clk_i) begin
      if (rst_ni && rsp_valid_o && rsp_ready_i) begin
         cap_data.push_back(rsp_rdata_o);
         cap_err.push_back(rsp_err_o);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
      int k;
      cmd_valid_i = 1'b1;
      cmd_wr_rd_i = wr;
      cmd_addr_i  = a;
      cmd_wdata_i = d;
      k = 0;
      while (!cmd_ready_o && k < 50) begin
         @(negedge clk_i);
         k++;
      end
      if (k == 50) check("push_ready_wait", {63'h0, cmd_ready_o}, 64'h1);
      @(posedge clk_i);
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_caps(input int n);
      int k;
      k = 0;
      while (cap_data.size() < n && k < 200) begin
         @(negedge clk_i);
         k++;
      end
      check("rsp_count", 64'(cap_data.size()), 64'(n));
   endtask

   initial begin
      int n;
      int k;
      int base;
      int hi_v;
      int hi_r;
      logic [W-1:0] exp6 [6];

      // Reset state
      rsp_ready_i = 1'b1;
      repeat (2) @(negedge clk_i);
      check("rst_cmd_ready", {63'h0, cmd_ready_o}, 64'h0);
      check("rst_valid",     {63'h0, valid_o},     64'h0);
      check("rst_rsp_valid", {63'h0, rsp_valid_o}, 64'h0);
      check("rst_rsp_err",   {63'h0, rsp_err_o},   64'h0);
      check("rst_rsp_rdata", 64'(rsp_rdata_o),     64'h0);
      check("rst_addr",      64'(addr_o),          64'h0);
      check("rst_wdata",     64'(wdata_o),         64'h0);
      check("rst_wr_rd",     {63'h0, wr_rd_o},     64'h0);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      check("rel_cmd_ready", {63'h0, cmd_ready_o}, 64'h1);
      @(negedge clk_i);

      // Write 0xDEADBEEF to address 3, then read it back
      push(1'b1, 4'h3, 32'hDEADBEEF);
      n = 0;
      while (!rsp_valid_o && n < 20) begin
         @(negedge clk_i);
         n++;
         if (n == 1) begin
            check("setup_valid", {63'h0, valid_o}, 64'h0);
            check("setup_addr",  64'(addr_o),      64'h3);
            check("setup_wr",    {63'h0, wr_rd_o}, 64'h1);
            check("setup_wdata", 64'(wdata_o),     64'hDEADBEEF);
         end
         if (n == 2) check("access_valid", {63'h0, valid_o}, 64'h1);
      end
      check("wr_latency", 64'(n),           64'h4);
      check("wr_rdata",   64'(rsp_rdata_o), 64'h0);
      check("wr_err",     {63'h0, rsp_err_o}, 64'h0);

      push(1'b0, 4'h3, 32'h0);
      n = 0;
      while (!rsp_valid_o && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      check("rd_latency", 64'(n),           64'h4);
      check("rd_rdata",   64'(rsp_rdata_o), 64'hDEADBEEF);
      check("rd_err",     {63'h0, rsp_err_o}, 64'h0);
      @(negedge clk_i);

      // Five back-to-back commands against a depth-4 queue
      base = cap_data.size();
      push(1'b1, 4'h5, 32'h11111111);
      push(1'b1, 4'h6, 32'h22222222);
      push(1'b0, 4'h5, 32'h0);
      push(1'b0, 4'h6, 32'h0);
      push(1'b0, 4'h3, 32'h0);
      check("full_ready_low", {63'h0, cmd_ready_o}, 64'h0);
      wait_caps(base + 5);
      check("b2b_0", 64'(cap_data[base+0]), 64'h0);
      check("b2b_1", 64'(cap_data[base+1]), 64'h0);
      check("b2b_2", 64'(cap_data[base+2]), 64'h11111111);
      check("b2b_3", 64'(cap_data[base+3]), 64'h22222222);
      check("b2b_4", 64'(cap_data[base+4]), 64'hDEADBEEF);
      for (int i = 0; i < 5; i++) check("b2b_err", {63'h0, cap_err[base+i]}, 64'h0);

      // Timeout with ready_i tied low, then hold the response
      @(negedge clk_i);
      slave_en    = 1'b0;
      rsp_ready_i = 1'b0;
      base = cap_data.size();
      push(1'b0, 4'h5, 32'h0);
      k = 0;
      while (!valid_o && k < 10) begin
         @(negedge clk_i);
         k++;
      end
      n = 0;
      while (valid_o && n < 40) begin
         @(negedge clk_i);
         n++;
      end
      check("tmo_access_cycles", 64'(n),             64'd16);
      check("tmo_rsp_valid",     {63'h0, rsp_valid_o}, 64'h1);
      check("tmo_err",           {63'h0, rsp_err_o},   64'h1);
      check("tmo_rdata",         64'(rsp_rdata_o),     64'h0);
      push(1'b0, 4'h6, 32'h0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         check("hold_rsp_valid", {63'h0, rsp_valid_o}, 64'h1);
         check("hold_err",       {63'h0, rsp_err_o},   64'h1);
         check("hold_rdata",     64'(rsp_rdata_o),     64'h0);
         check("hold_no_access", {63'h0, valid_o},     64'h0);
         check("hold_no_setup",  64'(addr_o),          64'h5);
      end
      slave_en    = 1'b1;
      rsp_ready_i = 1'b1;
      wait_caps(base + 2);
      check("tmo_cap_err",   {63'h0, cap_err[base]},   64'h1);
      check("tmo_cap_data",  64'(cap_data[base]),      64'h0);
      check("after_tmo_data", 64'(cap_data[base+1]),   64'h22222222);
      check("after_tmo_err", {63'h0, cap_err[base+1]}, 64'h0);

      // Simultaneous push and pop with two entries queued
      rsp_ready_i = 1'b0;
      base = cap_data.size();
      push(1'b0, 4'h3, 32'h0);
      push(1'b1, 4'h7, 32'h00000077);
      push(1'b0, 4'h7, 32'h0);
      k = 0;
      while (!rsp_valid_o && k < 20) begin
         @(negedge clk_i);
         k++;
      end
      check("cnt2_ready", {63'h0, cmd_ready_o}, 64'h1);
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      push(1'b1, 4'h8, 32'h00000088);
      check("pushpop_ready", {63'h0, cmd_ready_o}, 64'h1);
      push(1'b0, 4'h8, 32'h0);
      check("cnt3_ready", {63'h0, cmd_ready_o}, 64'h1);
      push(1'b0, 4'h5, 32'h0);
      check("cnt4_ready", {63'h0, cmd_ready_o}, 64'h0);
      rsp_ready_i = 1'b1;
      wait_caps(base + 6);
      exp6[0] = 32'hDEADBEEF; exp6[1] = 32'h0; exp6[2] = 32'h00000077;
      exp6[3] = 32'h0;        exp6[4] = 32'h00000088; exp6[5] = 32'h11111111;
      for (int i = 0; i < 6; i++) begin
         check("order_data", 64'(cap_data[base+i]), 64'(exp6[i]));
         check("order_err",  {63'h0, cap_err[base+i]}, 64'h0);
      end

      // Reset during ACCESS discards everything
      @(negedge clk_i);
      slave_en = 1'b0;
      push(1'b0, 4'h3, 32'h0);
      push(1'b0, 4'h5, 32'h0);
      k = 0;
      while (!valid_o && k < 10) begin
         @(negedge clk_i);
         k++;
      end
      check("pre_rst_valid", {63'h0, valid_o}, 64'h1);
      #2;
      rst_ni = 1'b0;
      #1;
      check("arst_valid",     {63'h0, valid_o},     64'h0);
      check("arst_cmd_ready", {63'h0, cmd_ready_o}, 64'h0);
      check("arst_rsp_valid", {63'h0, rsp_valid_o}, 64'h0);
      check("arst_addr",      64'(addr_o),          64'h0);
      base = cap_data.size();
      slave_en = 1'b1;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      check("rel2_cmd_ready", {63'h0, cmd_ready_o}, 64'h1);
      hi_v = 0;
      hi_r = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_i);
         if (valid_o)     hi_v++;
         if (rsp_valid_o) hi_r++;
      end
      check("post_rst_no_access", 64'(hi_v), 64'h0);
      check("post_rst_no_rsp",    64'(hi_r), 64'h0);
      check("post_rst_no_caps",   64'(cap_data.size()), 64'(base));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
